if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage. It owns the program counter, issues in-order word requests to instruction memory over a valid/ready request channel, and accepts responses with variable latency. Responses are buffered with their PC and handed to the IF/ID pipeline register through a valid/ready pair. It also handles branch/jump redirects, including squashing responses that are still in flight.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0
MAX_OUTSTANDING, 2, maximum imem requests issued but not yet responded (1..4)
FIFO_DEPTH, 2, response buffer entries; must be >= MAX_OUTSTANDING
NOP_INSTR, 32'h0000_0013, instruction presented when no valid instruction is available

Ports:
clk  in  1  clock. One clock; reset is synchronous and active-high.
rst  in  1  synchronous active-high reset, sampled on posedge clk
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  response valid; always accepted, in request order
imem_rsp_data  in  32  instruction word
out_valid  out  1  instruction_out/PC_out valid toward IF/ID
out_ready  in  1  IF/ID will latch this cycle (its clock-gate enable)
instruction_out  out  32  head instruction, or NOP_INSTR when empty
PC_out  out  32  PC of head instruction
redirect_valid  in  1  branch/jump taken; flush and refetch
redirect_pc  in  32  new fetch PC; bits [1:0] forced to 0
halt  in  1  stop issuing new requests (e.g. ecall/ebreak)

Behaviour:
- Reset: fetch_pc = resp_pc = RESET_PC; outstanding = 0; drop_cnt = 0; FIFO empty; state = S_BOOT. imem_req_valid = 0, out_valid = 0, instruction_out = NOP_INSTR, PC_out = RESET_PC.
- States:
  - S_BOOT lasts one cycle, then moves to S_RUN.
  - From S_RUN, halt=1 (and no redirect) moves to S_HALT.
  - From S_HALT, redirect_valid moves to S_RUN. halt alone being released does not leave S_HALT.
  - Redirect in any state other than S_BOOT moves to S_RUN.
- Request rule:
  - imem_req_valid = (state==S_RUN) && !halt && !redirect_valid && outstanding < MAX_OUTSTANDING && (outstanding + fifo_count) < FIFO_DEPTH.
  - imem_req_addr = fetch_pc.
  - imem_req_valid must not drop while waiting for ready unless redirect or halt is asserted.
  - On handshake: fetch_pc += 4 (32-bit wrap from 0xFFFF_FFFC to 0), outstanding += 1.
- Response rule: each imem_rsp_valid decrements outstanding.
  - If drop_cnt > 0, or redirect_valid is high this cycle: discard the response and decrement drop_cnt if nonzero.
  - Otherwise push {imem_rsp_data, resp_pc} into the FIFO and increment resp_pc by 4.
  - The FIFO can never overflow because of the credit rule; overflow is an assertion failure.
- Output:
  - out_valid = FIFO not empty; head is shown combinationally from FIFO storage.
  - Pop when out_valid && out_ready.
  - When empty: instruction_out = NOP_INSTR, PC_out holds the last popped PC.
  - Latency: response to out_valid is 1 cycle; request accept to earliest out_valid is memory latency + 1.
- Redirect, same cycle:
  - fetch_pc = resp_pc = {redirect_pc[31:2],2'b00}; FIFO flushed; any pop is ignored.
  - drop_cnt = outstanding after this cycle's response decrement.
  - No request is issued.
  - Redirect has priority over halt, pop and push.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged.
- Reset mid-operation: all state cleared. Responses still arriving for pre-reset requests are the memory's responsibility; the memory is reset by the same rst.

Optional Feature:
FETCH_PERF_CNT_EN: when defined, adds outputs perf_stall_cycles[31:0] and perf_squashed[31:0].
- perf_stall_cycles increments on each out_valid && !out_ready cycle.
- perf_squashed increments on each discarded response plus each FIFO entry flushed.
- Both counters saturate at 0xFFFF_FFFF and clear on rst.
When undefined: ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg: state enum (S_BOOT, S_RUN, S_HALT), XLEN=32, INSTR_BYTES=4, default NOP constant.
- Sub-module fetch_fifo: synchronous FIFO, parameterised width and depth, with push/pop/flush, count, and head peek.

Test Plan:
1. Zero-wait memory returning data=addr, out_ready=1 -> out PCs 0x0,0x4,0x8 on consecutive cycles; instruction_out equals PC; no bubbles after fill.
2. out_ready=0 for 5 cycles -> FIFO fills to 2 and imem_req_valid=0; after release, 0x0 and 0x4 pop in order with no loss or duplicates.
3. 3-cycle response latency with 2 outstanding; redirect_pc=0x100 while both are in flight -> drop_cnt=2, both responses discarded, next out PC=0x100.
4. Redirect in the same cycle as a response and a pop, target 0x203 -> response discarded, fetch resumes at 0x200, FIFO empty next cycle.
5. halt=1 at PC 0x40 -> no further requests; buffered instructions still drain; redirect 0x80 resumes fetching at 0x80.
6. rst asserted mid-stream -> next cycle out_valid=0, instruction_out=0x00000013, PC_out=RESET_PC; first request to RESET_PC issued two cycles after rst deasserts.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: imem request/response channel plus the IF/ID output pair.
// master = fetch unit side, slave = memory / IF-ID side.
interface if_fetch_unit_if;
  import fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] instruction_out;
  logic [XLEN-1:0] PC_out;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, instruction_out, PC_out,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, instruction_out, PC_out,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, occupancy count and combinational head peek.
module fetch_fifo #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

  // Pointer/count next state; flush wins over push and pop.
  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full || do_pop);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = ptr_inc(wr_q);
      if (do_pop)  rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= push_data_i;
  end

  // The fetch credit rule must keep pushes from ever hitting a full FIFO.
  assert property (@(posedge clk) disable iff (rst)
    !(push_i && full && !pop_i && !flush_i));

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests under a
// credit limit, buffers responses with their PC and hands them to IF/ID.
// Redirects flush the buffer and squash responses still in flight.
// Optional macro FETCH_PERF_CNT_EN adds stall/squash performance counters.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter int unsigned     FIFO_DEPTH      = 2,
  parameter logic [XLEN-1:0] NOP_INSTR       = NOP_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  if_fetch_unit_if.master       bus,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc,
  input  logic                  halt
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_squashed
`endif
);

  localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENT_W  = 2 * XLEN;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [XLEN-1:0]     last_pc_q, last_pc_d, redirect_tgt;
  logic [OUT_W-1:0]    outst_q, outst_d, drop_q, drop_d;
  logic                req_valid, req_fire, rsp_keep, rsp_drop, pop_fire;
  logic [FCNT_W-1:0]   fifo_count;
  logic                fifo_empty;
  logic [ENT_W-1:0]    fifo_head;

  assign redirect_tgt = redirect_pc & ~XLEN'(INSTR_BYTES - 1);

  // Next state and request-valid; credits count both in-flight and buffered words.
  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    unique case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (!redirect_valid && halt) state_d = S_HALT;
        req_valid = !halt && !redirect_valid
                 && (outst_q < OUT_W'(MAX_OUTSTANDING))
                 && ((32'(outst_q) + 32'(fifo_count)) < 32'(FIFO_DEPTH));
      end
      S_HALT: if (redirect_valid) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  // PC, credit and squash bookkeeping; a redirect overrides pop, push and halt.
  always_comb begin
    req_fire   = req_valid && bus.imem_req_ready;
    rsp_drop   = bus.imem_rsp_valid && ((drop_q != '0) || redirect_valid);
    rsp_keep   = bus.imem_rsp_valid && !rsp_drop;
    pop_fire   = !fifo_empty && bus.out_ready && !redirect_valid;
    outst_d    = outst_q + OUT_W'(req_fire) - OUT_W'(bus.imem_rsp_valid);
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    last_pc_d  = last_pc_q;
    drop_d     = drop_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_tgt;
      resp_pc_d  = redirect_tgt;
      drop_d     = outst_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
      if (rsp_keep) resp_pc_d  = resp_pc_q + XLEN'(INSTR_BYTES);
      if (rsp_drop) drop_d     = drop_q - OUT_W'(1);
      if (pop_fire) last_pc_d  = fifo_head[XLEN-1:0];
    end
  end

  // Control and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      last_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      last_pc_q  <= last_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (rsp_keep),
    .push_data_i ({bus.imem_rsp_data, resp_pc_q}),
    .pop_i       (pop_fire),
    .flush_i     (redirect_valid),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  assign bus.imem_req_valid  = req_valid;
  assign bus.imem_req_addr   = fetch_pc_q;
  assign bus.out_valid       = !fifo_empty;
  assign bus.instruction_out = fifo_empty ? NOP_INSTR : fifo_head[ENT_W-1:XLEN];
  assign bus.PC_out          = fifo_empty ? last_pc_q : fifo_head[XLEN-1:0];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q, squash_q;
  logic [32:0] squash_sum;

  // Squashes this cycle: one discarded response plus every flushed entry.
  always_comb begin
    squash_sum = {1'b0, squash_q} + 33'(rsp_drop)
               + (redirect_valid ? 33'(fifo_count) : 33'd0);
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      squash_q <= '0;
    end else begin
      if (!fifo_empty && !bus.out_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      squash_q <= squash_sum[32] ? '1 : squash_sum[31:0];
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_squashed     = squash_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a queue-based reference model of the
// fetch stage is compared against the DUT every cycle, plus literal pins.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          MAXO   = 2;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;

  always #5 clk = ~clk;

  if_fetch_unit_if bus();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_squashed;
`endif

  if_fetch_unit #(
    .RESET_PC        (RST_PC),
    .MAX_OUTSTANDING (MAXO),
    .FIFO_DEPTH      (DEPTH),
    .NOP_INSTR       (NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_squashed     (perf_squashed)
`endif
  );

  int unsigned n_pass = 0, n_checks = 0, cyc = 0;
  int unsigned mem_lat = 0;
  logic [31:0] data_xor = '0;

  typedef struct {logic [31:0] addr; int unsigned due;} mreq_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  mreq_t mq[$];
  ent_t  mf[$];

  logic [31:0] m_fetch, m_resp, m_last;
  int          m_out, m_drop;
  bit          m_boot, m_halted, m_known = 1'b0;

  logic [31:0] popped[$], issued[$];
  int unsigned pop_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] pop_at(input int i);
    return (popped.size() > i) ? popped[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] iss_at(input int i);
    return (issued.size() > i) ? issued[i] : 32'hDEAD_DEAD;
  endfunction

  // One clock cycle: memory response, compare against model, advance model.
  task automatic cycle();
    bit          hs, rsp, exp_rv, hs_m;
    logic [31:0] rdata, exp_instr, exp_pc;
    int          out_n;
    mreq_t       r;
    ent_t        e;
    exp_rv = 1'b0;
    #1;
    hs = bus.imem_req_valid && bus.imem_req_ready;
    if (hs) begin
      r.addr = bus.imem_req_addr;
      r.due  = cyc + mem_lat;
      mq.push_back(r);
    end
    rsp = 1'b0;
    rdata = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      rsp = 1'b1;
      rdata = mq[0].addr ^ data_xor;
      void'(mq.pop_front());
    end
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rdata;
    #1;
    if (m_known) begin
      exp_rv = !m_boot && !m_halted && !halt && !redirect_valid
            && (m_out < MAXO) && ((m_out + mf.size()) < DEPTH);
      exp_instr = (mf.size() > 0) ? mf[0].instr : NOP;
      exp_pc    = (mf.size() > 0) ? mf[0].pc : m_last;
      check("out_valid", 32'(bus.out_valid), 32'(mf.size() > 0));
      check("instruction_out", bus.instruction_out, exp_instr);
      check("PC_out", bus.PC_out, exp_pc);
      check("imem_req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
      if (exp_rv) check("imem_req_addr", bus.imem_req_addr, m_fetch);
    end
    if (!rst && hs) issued.push_back(bus.imem_req_addr);
    if (!rst && bus.out_valid && bus.out_ready && !redirect_valid) begin
      popped.push_back(bus.PC_out);
      pop_cyc.push_back(cyc);
    end
    if (rst) begin
      mf.delete();
      mq.delete();
      m_fetch = RST_PC; m_resp = RST_PC; m_last = RST_PC;
      m_out = 0; m_drop = 0; m_boot = 1'b1; m_halted = 1'b0; m_known = 1'b1;
    end else if (m_known) begin
      hs_m  = exp_rv && bus.imem_req_ready;
      out_n = m_out + (hs_m ? 1 : 0) - (rsp ? 1 : 0);
      if (redirect_valid) begin
        mf.delete();
        m_fetch = redirect_pc & 32'hFFFF_FFFC;
        m_resp  = m_fetch;
        m_drop  = out_n;
      end else begin
        if (mf.size() > 0 && bus.out_ready) begin
          m_last = mf[0].pc;
          void'(mf.pop_front());
        end
        if (rsp) begin
          if (m_drop > 0) m_drop--;
          else begin
            e.pc = m_resp; e.instr = rdata;
            mf.push_back(e);
            m_resp += 32'd4;
          end
        end
        if (hs_m) m_fetch += 32'd4;
      end
      m_out = out_n;
      if (m_boot) m_boot = 1'b0;
      else if (redirect_valid) m_halted = 1'b0;
      else if (halt) m_halted = 1'b1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bus.out_ready = 1'b1; bus.imem_req_ready = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    popped.delete(); issued.delete(); pop_cyc.delete();
  endtask

  initial begin
    bit found;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.out_ready      = 1'b1;

    // 1: zero-wait memory, data = addr, continuous drain
    mem_lat = 0; data_xor = '0;
    do_reset();
    repeat (8) cycle();
    check("t1_pop0", pop_at(0), 32'h0);
    check("t1_pop1", pop_at(1), 32'h4);
    check("t1_pop2", pop_at(2), 32'h8);
    check("t1_no_bubble", (pop_cyc.size() > 2) ? pop_cyc[2] - pop_cyc[0] : 32'hFFFF, 32'd2);

    // 2: back-pressure fills the buffer and stops requests
    data_xor = 32'h5A00_0000;
    do_reset();
    bus.out_ready = 1'b0;
    repeat (5) cycle();
    #1;
    check("t2_req_blocked", 32'(bus.imem_req_valid), 32'd0);
    check("t2_out_valid", 32'(bus.out_valid), 32'd1);
    check("t2_head_instr", bus.instruction_out, 32'h5A00_0000);
    bus.out_ready = 1'b1;
    repeat (6) cycle();
    check("t2_pop0", pop_at(0), 32'h0);
    check("t2_pop1", pop_at(1), 32'h4);
    check("t2_pop2", pop_at(2), 32'h8);

    // 3: redirect with two responses in flight, 3-cycle latency
    mem_lat = 3;
    do_reset();
    repeat (3) cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    popped.delete(); issued.delete();
    repeat (12) cycle();
    check("t3_first_req", iss_at(0), 32'h100);
    check("t3_pop0", pop_at(0), 32'h100);
    check("t3_pop1", pop_at(1), 32'h104);

    // 4: redirect colliding with a response and a pop, unaligned target
    mem_lat = 1;
    do_reset();
    repeat (3) cycle();
    #1;
    check("t4_pre_out_valid", 32'(bus.out_valid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    cycle();
    redirect_valid = 1'b0;
    #1;
    check("t4_fifo_empty", 32'(bus.out_valid), 32'd0);
    check("t4_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("t4_req_addr", bus.imem_req_addr, 32'h200);
    popped.delete();
    repeat (4) cycle();
    check("t4_pop0", pop_at(0), 32'h200);

    // 5: halt at 0x40, drain, halt release is not enough, redirect resumes
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      #1;
      if (bus.imem_req_valid && bus.imem_req_addr == 32'h40) found = 1'b1;
      else cycle();
    end
    check("t5_reach_0x40", 32'(found), 32'd1);
    halt = 1'b1;
    issued.delete(); popped.delete();
    repeat (8) cycle();
    check("t5_no_req_halt", 32'(issued.size()), 32'd0);
    check("t5_drain_last", (popped.size() > 0) ? popped[popped.size()-1] : 32'hDEAD_DEAD, 32'h3C);
    halt = 1'b0;
    repeat (3) cycle();
    check("t5_halt_sticky", 32'(issued.size()), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    cycle();
    redirect_valid = 1'b0;
    popped.delete();
    repeat (6) cycle();
    check("t5_resume_req", iss_at(0), 32'h80);
    check("t5_resume_pop", pop_at(0), 32'h80);

    // 6: reset mid-stream
    mem_lat = 0;
    do_reset();
    repeat (6) cycle();
    rst = 1'b1;
    cycle();
    #1;
    check("t6_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_instr_nop", bus.instruction_out, 32'h0000_0013);
    check("t6_pc_reset", bus.PC_out, RST_PC);
    check("t6_no_req", 32'(bus.imem_req_valid), 32'd0);
    rst = 1'b0;
    cycle();
    #1;
    check("t6_boot_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("t6_boot_req_addr", bus.imem_req_addr, RST_PC);
    repeat (4) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
